// File: rtl/uart_tx_frame.sv
// UART transmitter with a one-entry holding buffer so consecutive frames leave
// back-to-back. Bit timing is derived from a shared oversampling sample_tick.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 tx_reg;

  logic accept;
  logic bit_end;
  logic last_stop;
  logic load;

  assign accept    = tx_valid & ~hold_full;
  assign bit_end   = (state != S_IDLE) && sample_tick && (tick == TICK_LAST);
  assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // A full buffer is loaded either from idle or on the final stop-bit edge,
  // which is what removes the idle gap between consecutive frames.
  assign load      = hold_full && ((state == S_IDLE) || last_stop);

  assign tx_ready     = ~hold_full;
  assign tx_busy      = (state != S_IDLE);
  assign tx_done_tick = last_stop;
  assign tx           = tx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '1;
      parity_bit <= 1'b0;
      tick       <= '0;
      bit_cnt    <= '0;
      tx_reg     <= 1'b1;
    end else begin
      // accept and load are mutually exclusive: one needs the buffer empty,
      // the other needs it full.
      if (accept) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        state      <= S_START;
        shift_reg  <= hold_reg;
        parity_bit <= (PARITY == 1) ? ~(^hold_reg) : (^hold_reg);
        tick       <= '0;
        bit_cnt    <= '0;
        tx_reg     <= 1'b0;
      end else if ((state != S_IDLE) && sample_tick) begin
        if (!bit_end) begin
          tick <= tick + 1'b1;
        end else begin
          tick <= '0;
          case (state)
            S_START: begin
              state  <= S_DATA;
              tx_reg <= shift_reg[0];
            end
            S_DATA: begin
              shift_reg <= {1'b1, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (PARITY != 0) begin
                  state  <= S_PARITY;
                  tx_reg <= parity_bit;
                end else begin
                  state  <= S_STOP;
                  tx_reg <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_reg  <= shift_reg[1];
              end
            end
            S_PARITY: begin
              state  <= S_STOP;
              tx_reg <= 1'b1;
            end
            S_STOP: begin
              if (bit_cnt == STOP_LAST) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                tx_reg  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: begin
              state  <= S_IDLE;
              tx_reg <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover the default, even
// parity, odd parity and 7-bit/2-stop/8x configurations.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick;
  int         tick_div = 1;
  int         div_cnt = 0;
  logic [8:0] dv [4];
  logic [3:0] vld = 4'b0;
  logic [3:0] rdy, busy, done, txl;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int done_total = 0;

  logic line_buf [0:2047];
  int   rec_len, rec_done_at, rec_done_cnt;

  always #5 clk = ~clk;

  assign sample_tick = (div_cnt == 0);
  always @(posedge clk) div_cnt <= (div_cnt + 1 >= tick_div) ? 0 : div_cnt + 1;

  always @(negedge clk) if (done[sel]) done_total++;

  uart_tx_frame u_def (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .tx_data(dv[0][7:0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx_busy(busy[0]), .tx_done_tick(done[0]), .tx(txl[0]));

  uart_tx_frame #(.PARITY(2)) u_even (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .tx_data(dv[1][7:0]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx_busy(busy[1]), .tx_done_tick(done[1]), .tx(txl[1]));

  uart_tx_frame #(.PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .tx_data(dv[2][7:0]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .tx_busy(busy[2]), .tx_done_tick(done[2]), .tx(txl[2]));

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(8)) u_d7 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .tx_data(dv[3][6:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
    .tx_busy(busy[3]), .tx_done_tick(done[3]), .tx(txl[3]));

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int inst, input logic [8:0] d, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    dv[inst] = d;
    vld[inst] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (rdy[inst]) begin
        @(posedge clk);
        @(negedge clk);
        vld[inst] = 1'b0;
        ok = 1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!ok) begin
      vld[inst] = 1'b0;
      checks++; errors++;
      $display("FAIL send_timeout inst=%0d data=%h never accepted", inst, d);
    end
  endtask

  // Records tx of instance sel per cycle from the start-bit fall until busy drops.
  task automatic record(input int max_cyc);
    bit found;
    int idx;
    found = 0;
    rec_len = 0; rec_done_cnt = 0; rec_done_at = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (txl[sel] == 1'b0) begin found = 1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL record_start inst=%0d no start bit seen", sel);
      return;
    end
    idx = 0;
    while (idx < max_cyc) begin
      line_buf[idx] = txl[sel];
      if (done[sel]) begin
        if (rec_done_cnt == 0) rec_done_at = idx;
        rec_done_cnt++;
      end
      idx++;
      @(negedge clk);
      if (!busy[sel]) break;
    end
    rec_len = idx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (txl !== 4'hF) begin errors++; $display("FAIL reset_tx got=%b exp=1111", txl); end
    checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready got=%b exp=1111", rdy); end
    checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default();
    logic [9:0] exp;
    int w;
    exp = {1'b1, 8'h55, 1'b0};
    sel = 0;
    send(0, 9'h055, w);
    record(400);
    checks++; if (rec_len !== 160) begin errors++; $display("FAIL def_len got=%0d exp=160", rec_len); end
    checks++; if (rec_done_cnt !== 1) begin errors++; $display("FAIL def_done_cnt got=%0d exp=1", rec_done_cnt); end
    checks++; if (rec_done_at !== 159) begin errors++; $display("FAIL def_done_at got=%0d exp=159", rec_done_at); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (line_buf[i*16+8] !== exp[i]) begin
        errors++; $display("FAIL def_bit%0d got=%b exp=%b", i, line_buf[i*16+8], exp[i]);
      end
    end
    checks++; if (txl[0] !== 1'b1) begin errors++; $display("FAIL def_idle_tx got=%b exp=1", txl[0]); end
  endtask

  task automatic test_parity();
    logic [10:0] exp [3];
    int inst [3];
    int w;
    exp[0] = {1'b1, 1'b1, 8'h07, 1'b0}; inst[0] = 1;
    exp[1] = {1'b1, 1'b0, 8'h03, 1'b0}; inst[1] = 1;
    exp[2] = {1'b1, 1'b0, 8'h07, 1'b0}; inst[2] = 2;
    for (int t = 0; t < 3; t++) begin
      sel = inst[t];
      send(inst[t], {1'b0, exp[t][8:1]}, w);
      record(400);
      checks++; if (rec_len !== 176) begin errors++; $display("FAIL par%0d_len got=%0d exp=176", t, rec_len); end
      checks++; if (rec_done_at !== 175) begin errors++; $display("FAIL par%0d_done_at got=%0d exp=175", t, rec_done_at); end
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (line_buf[i*16+8] !== exp[t][i]) begin
          errors++; $display("FAIL par%0d_bit%0d got=%b exp=%b", t, i, line_buf[i*16+8], exp[t][i]);
        end
      end
    end
  endtask

  task automatic test_d7_stop2();
    logic [9:0] exp;
    int w;
    exp = {2'b11, 7'h41, 1'b0};
    sel = 3;
    send(3, 9'h041, w);
    record(300);
    checks++; if (rec_len !== 80) begin errors++; $display("FAIL d7_len got=%0d exp=80", rec_len); end
    checks++; if (rec_done_cnt !== 1) begin errors++; $display("FAIL d7_done_cnt got=%0d exp=1", rec_done_cnt); end
    checks++; if (rec_done_at !== 79) begin errors++; $display("FAIL d7_done_at got=%0d exp=79", rec_done_at); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (line_buf[i*8+4] !== exp[i]) begin
        errors++; $display("FAIL d7_bit%0d got=%b exp=%b", i, line_buf[i*8+4], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp [3];
    int w1, w2, w3;
    logic rdy_between;
    exp[0] = {1'b1, 8'hA5, 1'b0};
    exp[1] = {1'b1, 8'h3C, 1'b0};
    exp[2] = {1'b1, 8'h99, 1'b0};
    sel = 0;
    fork
      record(700);
      begin
        send(0, 9'h0A5, w1);
        send(0, 9'h03C, w2);
        rdy_between = rdy[0];
        dv[0] = 9'h0FF;
        send(0, 9'h099, w3);
      end
    join
    checks++; if (rdy_between !== 1'b0) begin errors++; $display("FAIL b2b_ready_between got=%b exp=0", rdy_between); end
    checks++; if (w3 !== 159) begin errors++; $display("FAIL b2b_third_wait got=%0d exp=159", w3); end
    checks++; if (rec_len !== 480) begin errors++; $display("FAIL b2b_len got=%0d exp=480", rec_len); end
    checks++; if (rec_done_cnt !== 3) begin errors++; $display("FAIL b2b_done_cnt got=%0d exp=3", rec_done_cnt); end
    checks++; if (rec_done_at !== 159) begin errors++; $display("FAIL b2b_done_at got=%0d exp=159", rec_done_at); end
    checks++;
    if (line_buf[159] !== 1'b1 || line_buf[160] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got=%b%b exp=10", line_buf[159], line_buf[160]);
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (line_buf[f*160+i*16+8] !== exp[f][i]) begin
          errors++; $display("FAIL b2b_f%0d_bit%0d got=%b exp=%b", f, i, line_buf[f*160+i*16+8], exp[f][i]);
        end
      end
    end
  endtask

  task automatic test_slow_tick();
    int w, r;
    sel = 0;
    tick_div = 5;
    send(0, 9'h0F0, w);
    fork
      record(1000);
      begin
        repeat (300) @(negedge clk);
        dv[0] = 9'h000;
      end
    join
    r = -1;
    for (int k = 0; k < rec_len; k++) begin
      if (line_buf[k] === 1'b1) begin r = k; break; end
    end
    checks++; if (r < 396 || r > 400) begin errors++; $display("FAIL slow_rise got=%0d exp=396..400", r); end
    checks++; if (rec_len - r !== 400) begin errors++; $display("FAIL slow_tail got=%0d exp=400", rec_len - r); end
    checks++; if (rec_done_at !== rec_len - 1) begin errors++; $display("FAIL slow_done_at got=%0d exp=%0d", rec_done_at, rec_len - 1); end
    if (r >= 320) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (line_buf[r - 280 + i*80] !== (i >= 4)) begin
          errors++; $display("FAIL slow_bit%0d got=%b exp=%b", i, line_buf[r - 280 + i*80], (i >= 4));
        end
      end
      checks++; if (line_buf[r + 360] !== 1'b1) begin errors++; $display("FAIL slow_stop got=%b exp=1", line_buf[r + 360]); end
    end
    tick_div = 1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [9:0] exp;
    int w, snap;
    bit found;
    exp = {1'b1, 8'h81, 1'b0};
    sel = 0;
    send(0, 9'h05A, w);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (txl[0] == 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_start got=no_fall exp=fall"); end
    send(0, 9'h033, w);
    repeat (69) @(negedge clk);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", rdy[0]); end
    snap = done_total;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (txl[0] !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", txl[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", rdy[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    repeat (300) @(negedge clk);
    checks++; if (done_total !== snap) begin errors++; $display("FAIL rst_no_done got=%0d exp=%0d", done_total, snap); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_discard got=%b exp=0", busy[0]); end
    send(0, 9'h081, w);
    record(400);
    checks++; if (rec_len !== 160) begin errors++; $display("FAIL rst_len got=%0d exp=160", rec_len); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (line_buf[i*16+8] !== exp[i]) begin
        errors++; $display("FAIL rst_bit%0d got=%b exp=%b", i, line_buf[i*16+8], exp[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dv[i] = 9'h000;
    @(negedge clk);
    test_reset();
    test_default();
    test_parity();
    test_d7_stop2();
    test_back_to_back();
    test_slow_tick();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with configurable data width, parity, stop-bit count and oversampling ratio. It has a one-entry holding buffer behind a valid/ready handshake, so consecutive frames go out back-to-back with no idle gap. It sits between the thermometer's formatting logic and the serial pin and shares the baud-rate generator's `sample_tick` with the UART receiver.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `OVERSAMPLE`, 16, `sample_tick` pulses per bit period; legal range 4..32.

- `clk`  in  1  system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe from the baud-rate generator.
- `tx_data`  in  DATA_BITS  word to send, LSB first; sampled only on handshake.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  holding buffer empty; handshake occurs when `tx_valid & tx_ready`.
- `tx_busy`  out  1  state is not IDLE (a frame is on the line).
- `tx_done_tick`  out  1  one-cycle pulse when the final stop bit completes.
- `tx`  out  1  serial line; idles high.

## Operation
- Holding buffer `hold_reg`/`hold_full`:
  - A handshake writes `tx_data` into the buffer and sets `hold_full`.
  - `tx_ready = ~hold_full`, taken from the register only. There is no bypass: while full, `tx_ready` stays 0 even in the cycle the buffer drains.
- Loading the buffer into the shift register clears `hold_full`. At the same time:
  - the parity bit is computed from the loaded word: even = XOR of the data bits, odd = its inverse;
  - the tick and bit counters clear.
- States:
  - **IDLE**: `tx` = 1. If `hold_full`, load and go to START.
  - **START**: `tx` = 0.
  - **DATA**: `tx` = shift register bit 0; the register shifts right once per completed bit.
  - **PARITY**: skipped when `PARITY` = 0; `tx` = the parity bit.
  - **STOP**: `tx` = 1 for `STOP_BITS` bit periods.
- Bit period:
  - Tick counter width is `$clog2(OVERSAMPLE)`.
  - On `sample_tick`: if `tick == OVERSAMPLE-1`, the bit ends and `tick` returns to 0; otherwise `tick` increments.
  - Clock cycles without `sample_tick` hold all state.
- DATA ends after `DATA_BITS` bit periods, tracked by the bit counter (width `$clog2(DATA_BITS+1)`). STOP reuses the same counter for `STOP_BITS`.
- End of the final stop bit:
  - `tx_done_tick` = 1 in that cycle (combinational from state, `tick` and `sample_tick`).
  - If `hold_full`, load the buffer and go to START on the same edge, with no idle bit between frames.
  - Otherwise go to IDLE.
- Frame length is `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * OVERSAMPLE` sample ticks.
- Changes on `tx_data` after the handshake have no effect on the frame.
- `tx_valid` while `tx_ready` = 0 is ignored. The producer must hold `tx_data` and `tx_valid` until the handshake.

## Timing
- Reset values:
  - state IDLE, `tx` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done_tick` = 0;
  - `hold_full` = 0;
  - all counters 0;
  - shift register all ones.
- Reset mid-frame:
  - on the reset edge, `tx` returns to 1 and the buffer is discarded;
  - no `tx_done_tick` is produced;
  - the frame in progress is truncated.
- `tx` is driven from a register, so it is glitch-free.
- Start latency from IDLE:
  - handshake at edge E0;
  - `hold_full` = 1 after E0;
  - load at E1, so `tx` falls and `tx_busy` rises after E1.
- After the load, `tx_ready` returns to 1 at E1. A second word can therefore be accepted during the first frame's start bit.
- `sample_tick` arriving in the same cycle as the load is not counted toward the start bit. The start bit is exactly `OVERSAMPLE` ticks counted after entry.
- Handshake and end-of-frame in the same cycle: the load takes the old buffer contents (which are full, so no handshake occurred) and the buffer flag clears. Consistent with the no-bypass rule.

## Test plan
- Defaults, `sample_tick` every clock, send 0x55:
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each for 16 ticks;
  - `tx_done_tick` pulses once, 160 ticks after `tx` falls;
  - `tx_busy` then drops.
- `PARITY` = 2:
  - send 0x07: parity bit = 1, frame is 11 bits;
  - send 0x03: parity bit = 0;
  - with `PARITY` = 1, send 0x07: parity bit = 0.
- `DATA_BITS` = 7, `STOP_BITS` = 2, `OVERSAMPLE` = 8, send 0x41:
  - `tx` = 0,1,0,0,0,0,0,1,1,1;
  - total 80 ticks;
  - `tx_done_tick` occurs only after the second stop bit.
- Back-to-back 0xA5 then 0x3C, second offered while the first is in flight:
  - `tx_ready` = 0 between the two accepts;
  - `tx` goes from the stop bit straight to the next start bit on the `tx_done_tick` edge, with no idle high bit;
  - 0x3C is received intact;
  - a third `tx_valid` offered while full is not accepted until `tx_ready` = 1.
- `sample_tick` every 5 clocks, send 0xF0:
  - each bit lasts exactly 80 clocks;
  - changing `tx_data` to 0x00 mid-frame does not alter the output.
- Assert `reset` during data bit 3 with the buffer full:
  - next cycle `tx` = 1, `tx_ready` = 1, `tx_busy` = 0;
  - no `tx_done_tick`;
  - a subsequent send of 0x81 is correct.
